// File: rtl/bin2bcd_seq.sv
// ----------------------------------------------------------------------------
// bin2bcd_seq
//
// Sequential binary-to-BCD converter that feeds the eight-digit seven-segment
// tube driver. The converter uses shift-and-add-3 (double-dabble) and handles
// one input bit per clock. The packed BCD result is held between conversions.
// Nibble DIGITS-1 is the leftmost tube digit and nibble 0 is the rightmost.
// Inputs larger than 10^DIGITS-1 produce all nines and raise ovf.
//
// Ports
//   clk       in   system clock (50 MHz)
//   rst_n     in   asynchronous active-low reset
//   din_vld   in   single-cycle request; only sampled while busy = 0
//   din       in   unsigned binary value, sampled together with din_vld
//   busy      out  conversion in progress (registered)
//   dout      out  packed BCD result, updated only at the end of a conversion
//   dout_vld  out  one-cycle pulse when dout/ovf update
//   ovf       out  last accepted value exceeded 10^DIGITS-1
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for din_vld; outputs hold the previous result
// S_SHIFT | one add-3/shift step per clock, BIN_W steps in total
// S_DONE  | publish accumulator (or saturated nines) and pulse dout_vld
// ----------------------------------------------------------------------------
module bin2bcd_seq #(
   parameter int BIN_W  = 27,
   parameter int DIGITS = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  din_vld,
   input  logic [BIN_W-1:0]      din,
   output logic                  busy,
   output logic [4*DIGITS-1:0]   dout,
   output logic                  dout_vld,
   output logic                  ovf
);

   localparam int ACC_W = 4 * DIGITS;
   // Must count up to BIN_W without wrapping.
   localparam int CNT_W = $clog2(BIN_W + 1);

   // Largest displayable value, 10^DIGITS-1. It is held at 64 bits so the
   // overflow compare stays exact even when BIN_W is narrower than the
   // decimal range. In that case saturation can never happen.
   function automatic logic [63:0] max_dec(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) begin
         p = p * 64'd10;
      end
      return p - 64'd1;
   endfunction

   localparam logic [63:0]      MAX_DEC   = max_dec(DIGITS);
   localparam logic [ACC_W-1:0] ALL_NINES = {DIGITS{4'h9}};
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BIN_W - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_n_q, ovf_n_d;
   logic               busy_q, busy_d;
   logic [ACC_W-1:0]   dout_q, dout_d;
   logic               dout_vld_q, dout_vld_d;
   logic               ovf_q, ovf_d;

   logic [ACC_W-1:0]   acc_adj;
   logic [63:0]        din_wide;

   assign din_wide = 64'(din);

   // Add-3 correction. Each nibble of 5 or more gets 3 added before the
   // shift, so that the shift carries into the next decimal digit. The add
   // is 4 bits wide on purpose: a valid BCD digit of 5..9 plus 3 never
   // exceeds 4'hC, so nothing carries across nibbles.
   always_comb begin
      acc_adj = acc_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) begin
            acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      ovf_n_d    = ovf_n_q;
      dout_d     = dout_q;
      ovf_d      = ovf_q;
      dout_vld_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (din_vld) begin
               bin_d   = din;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_n_d = (din_wide > MAX_DEC);
               state_d = S_SHIFT;
            end
         end

         S_SHIFT: begin
            // {accumulator, binary} shifted left as one long register.
            acc_d = {acc_adj[ACC_W-2:0], bin_q[BIN_W-1]};
            bin_d = {bin_q[BIN_W-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            dout_d     = ovf_n_q ? ALL_NINES : acc_q;
            ovf_d      = ovf_n_q;
            dout_vld_d = 1'b1;
            state_d    = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // busy is registered from the next state, so it rises on the
      // accepting edge and falls on the same edge as dout_vld.
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         bin_q      <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         ovf_n_q    <= 1'b0;
         busy_q     <= 1'b0;
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         ovf_n_q    <= ovf_n_d;
         busy_q     <= busy_d;
         dout_q     <= dout_d;
         dout_vld_q <= dout_vld_d;
         ovf_q      <= ovf_d;
      end
   end

   assign busy     = busy_q;
   assign dout     = dout_q;
   assign dout_vld = dout_vld_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// ----------------------------------------------------------------------------
// tb_bin2bcd_seq
//
// Bench for bin2bcd_seq. The reference model works in plain decimal
// arithmetic: it peels off digits with %10 and saturates anything above
// 99_999_999. It checks latency, held outputs, busy filtering, back-to-back
// throughput and reset abort.
// ----------------------------------------------------------------------------
module tb_bin2bcd_seq;

   localparam int BIN_W  = 27;
   localparam int DIGITS = 8;
   localparam int LAT    = BIN_W + 1;

   logic                clk;
   logic                rst_n;
   logic                din_vld;
   logic [BIN_W-1:0]    din;
   logic                busy;
   logic [4*DIGITS-1:0] dout;
   logic                dout_vld;
   logic                ovf;

   int checks;
   int errors;

   bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .din_vld  (din_vld),
      .din      (din),
      .busy     (busy),
      .dout     (dout),
      .dout_vld (dout_vld),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   function automatic logic [31:0] model_bcd(input int unsigned v);
      logic [31:0] r;
      int unsigned x;
      r = '0;
      if (v > 32'd99_999_999) return 32'h9999_9999;
      x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic model_ovf(input int unsigned v);
      return (v > 32'd99_999_999);
   endfunction

   // Issue a request at the current negedge. The task returns at the negedge
   // after the accepting edge E0. When din_vld is low, din is scrambled so
   // that the DUT cannot rely on din being stable.
   task automatic start_req(input logic [BIN_W-1:0] v);
      din     = v;
      din_vld = 1'b1;
      @(negedge clk);
      din_vld = 1'b0;
      din     = BIN_W'($urandom);
   endtask

   // Count negedges from E0 until dout_vld. lat is -1 if the pulse never
   // arrives. held_ok drops if busy falls early or if dout/ovf move before
   // the pulse.
   task automatic wait_done(output int lat, output logic held_ok);
      logic [31:0] d0;
      logic        o0;
      d0      = dout;
      o0      = ovf;
      lat     = 0;
      held_ok = 1'b1;
      while (!dout_vld && lat < 60) begin
         if (!busy || dout !== d0 || ovf !== o0) held_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (!dout_vld) lat = -1;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      din_vld = 1'b0;
      din     = '0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (dout !== 32'h0) begin
            errors++; $display("FAIL reset_dout got %h want %h", dout, 32'h0);
         end
         checks++;
         if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b want 0", busy);
         end
         checks++;
         if (dout_vld !== 1'b0) begin
            errors++; $display("FAIL reset_vld got %b want 0", dout_vld);
         end
         checks++;
         if (ovf !== 1'b0) begin
            errors++; $display("FAIL reset_ovf got %b want 0", ovf);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int          lat;
      logic        held;
      logic [31:0] exp_d;
      exp_d = model_bcd(12_345_678);
      start_req(BIN_W'(12_345_678));
      wait_done(lat, held);
      checks++;
      if (lat !== LAT) begin
         errors++; $display("FAIL basic_latency got %0d want %0d", lat, LAT);
      end
      checks++;
      if (held !== 1'b1) begin
         errors++; $display("FAIL basic_held got %b want 1", held);
      end
      checks++;
      if (dout !== exp_d) begin
         errors++; $display("FAIL basic_dout got %h want %h", dout, exp_d);
      end
      checks++;
      if (ovf !== 1'b0) begin
         errors++; $display("FAIL basic_ovf got %b want 0", ovf);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL basic_busy_fall got %b want 0", busy);
      end
      @(negedge clk);
      checks++;
      if (dout_vld !== 1'b0) begin
         errors++; $display("FAIL basic_vld_width got %b want 0", dout_vld);
      end
      checks++;
      if (dout !== exp_d) begin
         errors++; $display("FAIL basic_hold got %h want %h", dout, exp_d);
      end
   endtask

   task automatic run_one(input string tag, input int unsigned v);
      int          lat;
      logic        held;
      logic [31:0] exp_d;
      logic        exp_o;
      exp_d = model_bcd(v);
      exp_o = model_ovf(v);
      start_req(BIN_W'(v));
      wait_done(lat, held);
      checks++;
      if (lat !== LAT) begin
         errors++; $display("FAIL %s_latency v=%0d got %0d want %0d", tag, v, lat, LAT);
      end
      checks++;
      if (dout !== exp_d) begin
         errors++; $display("FAIL %s_dout v=%0d got %h want %h", tag, v, dout, exp_d);
      end
      checks++;
      if (ovf !== exp_o) begin
         errors++; $display("FAIL %s_ovf v=%0d got %b want %b", tag, v, ovf, exp_o);
      end
      checks++;
      if (held !== 1'b1) begin
         errors++; $display("FAIL %s_held v=%0d got %b want 1", tag, v, held);
      end
      @(negedge clk);
   endtask

   task automatic test_boundaries();
      int unsigned vals[4] = '{0, 99_999_999, 100_000_000, 134_217_727};
      foreach (vals[i]) run_one("bound", vals[i]);
   endtask

   task automatic test_random();
      int unsigned v;
      for (int n = 0; n < 24; n++) begin
         if ($urandom_range(0, 3) == 0) v = $urandom_range(100_000_000, 134_217_727);
         else v = $urandom_range(0, 99_999_999);
         run_one("rand", v);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   task automatic test_ignore_busy();
      int          pulses;
      logic [31:0] seen;
      seen   = '0;
      pulses = 0;
      start_req(BIN_W'(5));
      repeat (9) @(negedge clk);
      din     = BIN_W'(777);
      din_vld = 1'b1;
      @(negedge clk);
      din_vld = 1'b0;
      for (int c = 0; c < 70; c++) begin
         if (dout_vld) begin
            pulses++;
            seen = dout;
         end
         @(negedge clk);
      end
      checks++;
      if (pulses !== 1) begin
         errors++; $display("FAIL ignore_pulses got %0d want 1", pulses);
      end
      checks++;
      if (seen !== 32'h0000_0005) begin
         errors++; $display("FAIL ignore_dout got %h want %h", seen, 32'h5);
      end
      checks++;
      if (dout !== 32'h0000_0005) begin
         errors++; $display("FAIL ignore_hold got %h want %h", dout, 32'h5);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL ignore_busy got %b want 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      int          k, k1, k2, p;
      logic [31:0] d1, d2;
      k = 0; k1 = -1; k2 = -1; p = 0; d1 = '0; d2 = '0;
      start_req(BIN_W'(42));
      while (k < 90) begin
         @(negedge clk);
         k++;
         din_vld = 1'b0;
         if (dout_vld) begin
            if (p == 0) begin
               k1 = k; d1 = dout;
               din = BIN_W'(1_000_000);
               din_vld = 1'b1;
            end else if (p == 1) begin
               k2 = k; d2 = dout;
            end
            p++;
         end
      end
      checks++;
      if (p !== 2) begin
         errors++; $display("FAIL b2b_pulses got %0d want 2", p);
      end
      checks++;
      if (k1 !== LAT) begin
         errors++; $display("FAIL b2b_first_latency got %0d want %0d", k1, LAT);
      end
      checks++;
      if (k2 - k1 !== LAT + 1) begin
         errors++; $display("FAIL b2b_spacing got %0d want %0d", k2 - k1, LAT + 1);
      end
      checks++;
      if (d1 !== model_bcd(42)) begin
         errors++; $display("FAIL b2b_dout1 got %h want %h", d1, model_bcd(42));
      end
      checks++;
      if (d2 !== model_bcd(1_000_000)) begin
         errors++; $display("FAIL b2b_dout2 got %h want %h", d2, model_bcd(1_000_000));
      end
   endtask

   task automatic test_abort();
      int pulses;
      pulses = 0;
      start_req(BIN_W'(87_654_321));
      repeat (14) @(negedge clk);
      @(posedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL abort_busy got %b want 0", busy);
      end
      checks++;
      if (dout !== 32'h0) begin
         errors++; $display("FAIL abort_dout got %h want %h", dout, 32'h0);
      end
      checks++;
      if (ovf !== 1'b0) begin
         errors++; $display("FAIL abort_ovf got %b want 0", ovf);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (dout_vld) pulses++;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (dout_vld) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         errors++; $display("FAIL abort_vld got %0d pulses want 0", pulses);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL abort_idle got %b want 0", busy);
      end
      run_one("abort_fresh", 87_654_321);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst_n   = 1'b0;
      din_vld = 1'b0;
      din     = '0;
      test_reset();
      test_basic();
      test_boundaries();
      test_ignore_busy();
      test_back_to_back();
      test_random();
      test_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter that sits directly upstream of the eight-digit seven-segment tube driver. It accepts an unsigned binary value, converts it with the shift-and-add-3 (double-dabble) algorithm at one bit per clock, and presents a held, packed 8-digit BCD word. That word drives the tube's 32-bit `din` directly: nibble 7 is the leftmost digit and nibble 0 the rightmost. Values above the displayable range saturate to all nines and are flagged.

## Interface
- `BIN_W`, 27, width of the binary input. 2^27−1 exceeds the 8-digit range, so saturation is reachable.
- `DIGITS`, 8, number of BCD digits. Output width is 4*DIGITS.
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `din_vld`  in  1  single-cycle request. Sampled only while `busy`=0.
- `din`  in  BIN_W  unsigned binary value. Sampled on the same edge as `din_vld`.
- `busy`  out  1  conversion in progress.
- `dout`  out  4*DIGITS  packed BCD result, held between conversions. Connects to the tube's `din`.
- `dout_vld`  out  1  one-cycle pulse when `dout`/`ovf` update.
- `ovf`  out  1  the last accepted value exceeded 10^DIGITS−1. Held with `dout`.

## Operation
- Reset values: state IDLE; `busy`=0, `dout`=0, `dout_vld`=0, `ovf`=0; all internal registers 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On `din_vld`=1, load `din` into the binary shift register.
  - Clear the BCD accumulator (4*DIGITS bits) and the bit counter.
  - Register `ovf_n` = (`din` > 10^DIGITS−1), compared at full BIN_W width.
  - Go to SHIFT.
- SHIFT, once per clock:
  - Every accumulator nibble ≥5 gets +3 (4-bit add, no carry out of the nibble).
  - Then shift {accumulator, binary reg} left by 1.
  - Counter increments; after BIN_W shifts go to DONE.
- DONE, one cycle:
  - `dout` ← accumulator, or all 4'h9 nibbles if `ovf_n`.
  - `ovf` ← `ovf_n`.
  - `dout_vld` pulses; go to IDLE.
- `busy` = (state != IDLE), registered.
- `din_vld` while `busy`=1 is ignored: no queueing and no effect on the conversion in flight.
- `dout` and `ovf` change only on the DONE edge. The tube never sees an intermediate value.
- Reset mid-conversion aborts immediately and returns all outputs to their reset values.
- Counter width is clog2(BIN_W+1). It must not wrap before BIN_W.

## Timing
- Let E0 be the edge sampling `din_vld`=1 in IDLE.
- `busy` is high from after E0 until after E(BIN_W+1).
- Shifts occur on E1..E(BIN_W).
- `dout`, `ovf` and `dout_vld`=1 are updated on E(BIN_W+1); `busy` falls on the same edge.
- Latency is BIN_W+1 clocks, i.e. 28 at defaults.
- The earliest next acceptance is E(BIN_W+2), giving one conversion per BIN_W+2 clocks (29).
- `dout_vld` is high for exactly one cycle per accepted request.

## Test plan
- Reset: assert `rst_n`=0 for 3 cycles → `dout`=32'h0000_0000, `busy`=0, `dout_vld`=0, `ovf`=0 throughout.
- Basic: `din`=12_345_678 with `din_vld` pulse → `busy` for 28 cycles; then `dout`=32'h1234_5678, `ovf`=0, one-cycle `dout_vld`. Check that exact latency.
- Boundaries:
  - `din`=0 → 32'h0000_0000.
  - `din`=99_999_999 → 32'h9999_9999 with `ovf`=0.
  - `din`=100_000_000 → 32'h9999_9999 with `ovf`=1.
  - `din`=134_217_727 → 32'h9999_9999 with `ovf`=1.
- Ignore while busy: convert 5 and pulse `din_vld` with 777 at E10 → result 32'h0000_0005, exactly one `dout_vld`, and `dout` held afterward.
- Back-to-back: issue 42, then 1_000_000 at E(BIN_W+2) → two `dout_vld` pulses 29 cycles apart, giving 32'h0000_0042 then 32'h0100_0000.
- Abort: start 87_654_321 and drop `rst_n` at E15 → outputs return to reset values asynchronously, no `dout_vld`. A fresh request of 87_654_321 after release → 32'h8765_4321.
